// File: rtl/bp_nonsynth_watchdog_pkg.sv
// Shared types and defaults for the multi-core watchdog and run monitor.
package bp_nonsynth_watchdog_pkg;

    typedef enum logic [1:0] {
        e_run,
        e_done,
        e_fail
    } bp_watchdog_state_e;

    localparam int unsigned timeout_cycles_default_lp  = 100000;
    localparam int unsigned heartbeat_instr_default_lp = 100000;

    // Index width that stays at least one bit for single-entry vectors.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_nonsynth_watchdog_core.sv
// Per-core tracker: idle/timeout detection, retired-instruction heartbeat
// request with overrun detection, and sticky program-finish capture.
module bp_nonsynth_watchdog_core
    import bp_nonsynth_watchdog_pkg::*;
#(
    parameter int vaddr_width_p     = 39,
    parameter int timeout_cycles_p  = timeout_cycles_default_lp,
    parameter int heartbeat_instr_p = heartbeat_instr_default_lp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     freeze_i,
    input  logic [vaddr_width_p-1:0] npc_i,
    input  logic                     instret_i,
    input  logic                     program_finish_i,
    input  logic                     hb_grant_i,
    output logic                     timeout_o,
    output logic                     hb_pend_o,
    output logic                     hb_overrun_o,
    output logic                     finish_o
);

    localparam int stall_width_lp = width_of(timeout_cycles_p);
    localparam int inst_width_lp  = width_of(heartbeat_instr_p);
    localparam logic [stall_width_lp-1:0] stall_last_lp = stall_width_lp'(timeout_cycles_p - 1);
    localparam logic [inst_width_lp-1:0]  inst_last_lp  = inst_width_lp'(heartbeat_instr_p - 1);

    logic [vaddr_width_p-1:0]  npc_q, npc_d;
    logic [stall_width_lp-1:0] stall_cnt_q, stall_cnt_d;
    logic [inst_width_lp-1:0]  inst_cnt_q, inst_cnt_d;
    logic                      timeout_q, timeout_d;
    logic                      hb_pend_q, hb_pend_d;
    logic                      hb_overrun_q, hb_overrun_d;
    logic                      finish_q, finish_d;
    logic                      progress;
    logic                      hb_set;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        progress     = instret_i | (npc_i != npc_q);
        npc_d        = npc_i;
        stall_cnt_d  = stall_cnt_q;
        timeout_d    = timeout_q;
        inst_cnt_d   = inst_cnt_q;
        hb_set       = 1'b0;
        finish_d     = finish_q | program_finish_i;

        if (freeze_i | finish_q | progress) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q == stall_last_lp) begin
            timeout_d = 1'b1;  // counter saturates here
        end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        if (instret_i & ~freeze_i) begin
            if (inst_cnt_q == inst_last_lp) begin
                inst_cnt_d = '0;
                hb_set     = 1'b1;
            end else begin
                inst_cnt_d = inst_cnt_q + 1'b1;
            end
        end

        // A grant in the same cycle retires the old request, so the new one is kept.
        hb_pend_d    = (hb_pend_q & ~hb_grant_i) | hb_set;
        hb_overrun_d = hb_overrun_q | (hb_set & hb_pend_q & ~hb_grant_i);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            npc_q        <= '0;
            stall_cnt_q  <= '0;
            inst_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            hb_pend_q    <= 1'b0;
            hb_overrun_q <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            npc_q        <= npc_d;
            stall_cnt_q  <= stall_cnt_d;
            inst_cnt_q   <= inst_cnt_d;
            timeout_q    <= timeout_d;
            hb_pend_q    <= hb_pend_d;
            hb_overrun_q <= hb_overrun_d;
            finish_q     <= finish_d;
        end
    end

    assign timeout_o    = timeout_q;
    assign hb_pend_o    = hb_pend_q;
    assign hb_overrun_o = hb_overrun_q;
    assign finish_o     = finish_q;

endmodule

// File: rtl/bp_nonsynth_watchdog_mc.sv
// Multi-core watchdog: per-core trackers, fixed-priority heartbeat arbiter and
// run/done/fail FSM. Define BP_NONSYNTH_WATCHDOG_DISPLAY_EN for console reporting.
module bp_nonsynth_watchdog_mc
    import bp_nonsynth_watchdog_pkg::*;
#(
    parameter int num_core_p        = 1,
    parameter int vaddr_width_p     = 39,
    parameter int timeout_cycles_p  = timeout_cycles_default_lp,
    parameter int heartbeat_instr_p = heartbeat_instr_default_lp
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [num_core_p-1:0]                      freeze_i,
    input  logic [num_core_p-1:0][vaddr_width_p-1:0]   npc_i,
    input  logic [num_core_p-1:0]                      instret_i,
    input  logic [num_core_p-1:0]                      program_finish_i,
    output logic [num_core_p-1:0]                      timeout_o,
    output logic [num_core_p-1:0]                      hb_overrun_o,
    output logic                                       heartbeat_v_o,
    output logic [width_of(num_core_p)-1:0]            heartbeat_core_o,
    output logic                                       all_finish_o,
    output logic                                       fail_o
);

    localparam int core_id_width_lp = width_of(num_core_p);

    logic [num_core_p-1:0]       hb_pend;
    logic [num_core_p-1:0]       hb_grant;
    logic [num_core_p-1:0]       finish;
    logic [core_id_width_lp-1:0] grant_id;
    logic                        grant_v;

    logic                        heartbeat_v_q, heartbeat_v_d;
    logic [core_id_width_lp-1:0] heartbeat_core_q, heartbeat_core_d;
    bp_watchdog_state_e          state_q;
    logic                        all_finish_q;
    logic                        fail_q;

    for (genvar i = 0; i < num_core_p; i++) begin : g_core
        bp_nonsynth_watchdog_core #(
            .vaddr_width_p    (vaddr_width_p),
            .timeout_cycles_p (timeout_cycles_p),
            .heartbeat_instr_p(heartbeat_instr_p)
        ) u_core (
            .clk_i           (clk_i),
            .reset_i         (reset_i),
            .freeze_i        (freeze_i[i]),
            .npc_i           (npc_i[i]),
            .instret_i       (instret_i[i]),
            .program_finish_i(program_finish_i[i]),
            .hb_grant_i      (hb_grant[i]),
            .timeout_o       (timeout_o[i]),
            .hb_pend_o       (hb_pend[i]),
            .hb_overrun_o    (hb_overrun_o[i]),
            .finish_o        (finish[i])
        );
    end

    // Scanning from the top down leaves the lowest pending index as the winner.
    always_comb begin
        hb_grant = '0;
        grant_id = '0;
        grant_v  = 1'b0;
        for (int i = num_core_p - 1; i >= 0; i--) begin
            if (hb_pend[i]) begin
                hb_grant    = '0;
                hb_grant[i] = 1'b1;
                grant_id    = core_id_width_lp'(i);
                grant_v     = 1'b1;
            end
        end
        heartbeat_v_d    = grant_v;
        heartbeat_core_d = grant_id;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            heartbeat_v_q    <= 1'b0;
            heartbeat_core_q <= '0;
        end else begin
            heartbeat_v_q    <= heartbeat_v_d;
            heartbeat_core_q <= heartbeat_core_d;
        end
    end

    // Failure outranks completion; both terminal states hold until reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= e_run;
            all_finish_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            case (state_q)
                e_run: begin
                    if ((|timeout_o) | (|hb_overrun_o)) begin
                        state_q <= e_fail;
                        fail_q  <= 1'b1;
                    end else if (&finish) begin
                        state_q      <= e_done;
                        all_finish_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign heartbeat_v_o    = heartbeat_v_q;
    assign heartbeat_core_o = heartbeat_core_q;
    assign all_finish_o     = all_finish_q;
    assign fail_o           = fail_q;

`ifdef BP_NONSYNTH_WATCHDOG_DISPLAY_EN
    logic [63:0]           cycle_q;
    logic [1:0]            fail_age_q;
    logic                  pass_shown_q;
    logic [num_core_p-1:0] timeout_seen_q;
    logic [num_core_p-1:0] overrun_seen_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q        <= '0;
            fail_age_q     <= '0;
            pass_shown_q   <= 1'b0;
            timeout_seen_q <= '0;
            overrun_seen_q <= '0;
        end else begin
            cycle_q        <= cycle_q + 1'b1;
            timeout_seen_q <= timeout_o;
            overrun_seen_q <= hb_overrun_o;
            if (heartbeat_v_q)
                $display("[watchdog] heartbeat core %0d cycle %0d npc %h",
                         heartbeat_core_q, cycle_q, npc_i[heartbeat_core_q]);
            for (int i = 0; i < num_core_p; i++) begin
                if (timeout_o[i] & ~timeout_seen_q[i])
                    $display("[watchdog] timeout core %0d cycle %0d npc %h", i, cycle_q, npc_i[i]);
                if (hb_overrun_o[i] & ~overrun_seen_q[i])
                    $display("[watchdog] heartbeat overrun core %0d cycle %0d", i, cycle_q);
            end
            if ((state_q == e_done) && !pass_shown_q) begin
                pass_shown_q <= 1'b1;
                $display("[watchdog] PASS: all %0d cores finished at cycle %0d", num_core_p, cycle_q);
            end
            if (state_q == e_fail) begin
                fail_age_q <= fail_age_q + 1'b1;
                if (fail_age_q == 2'd1) $finish;
            end
        end
    end
`else
    // Silent build: the outputs alone report status and the bench decides termination.
`endif

endmodule
